// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared encodings for the EX/MEM stage: ctrl bit indices, ALU
//            Signal codes, divider FSM state encoding and ctrl field width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int CTRL_W        = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_DIVU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam int         ST_W    = 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/div_busy_ctr.sv
// ============================================================================
// Module   : div_busy_ctr
// Brief    : IDLE/BUSY tracker for the multi-cycle DIVU; busy spans exactly
//            DIV_CYCLES cycles after an issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_busy_ctr
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic busy
);

    localparam int                 c_cnt_w    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [ST_W-1:0]    r_state;
    logic [c_cnt_w-1:0] r_cnt;

    // The count runs free once loaded; stalls and flushes never touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (issue) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= c_cnt_load;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_BUSY);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with DIVU busy interlock and stalls.
//            Optional forwarding outputs enabled by macro EXMEM_FWD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int         DIV_CYCLES = 32,
    parameter logic [3:0] DIVU_CODE  = ALU_DIVU
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [3:0]        ex_alu_sig,
    input  logic              ex_hilo_rd,
    input  logic [31:0]       ex_result,
    input  logic              ex_zero,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_wreg,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              ex_stall,
    output logic              mem_valid,
    output logic [31:0]       mem_result,
    output logic              mem_zero,
    output logic [31:0]       mem_store_data,
    output logic [4:0]        mem_wreg,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              div_busy
`ifdef EXMEM_FWD_EN
   ,output logic              fwd_valid,
    output logic [4:0]        fwd_wreg,
    output logic [31:0]       fwd_data
`endif
);

    logic w_busy;
    logic w_divu;
    logic w_busy_stall;
    logic w_issue;

    logic              r_valid;
    logic [31:0]       r_result;
    logic              r_zero;
    logic [31:0]       r_store_data;
    logic [4:0]        r_wreg;
    logic [CTRL_W-1:0] r_ctrl;

    assign w_divu       = (ex_alu_sig == DIVU_CODE);
    // Only HI/LO consumers and a second DIVU have to wait for the divider.
    assign w_busy_stall = w_busy & ex_valid & (ex_hilo_rd | w_divu);
    assign w_issue      = ~w_busy & ex_valid & w_divu & ~flush & ~mem_stall;
    assign ex_stall     = ~flush & (mem_stall | w_busy_stall);

    div_busy_ctr #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .issue (w_issue),
        .busy  (w_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_store_data <= '0;
            r_wreg       <= '0;
            r_ctrl       <= '0;
        end else if (!mem_stall) begin
            if (flush || !ex_valid || w_busy_stall) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else begin
                r_valid      <= 1'b1;
                r_result     <= ex_result;
                r_zero       <= ex_zero;
                r_store_data <= ex_store_data;
                r_wreg       <= ex_wreg;
                // DIVU writes HI/LO inside the divider, never the register file or memory.
                r_ctrl       <= w_divu ? '0 : ex_ctrl;
            end
        end
    end

    assign mem_valid      = r_valid;
    assign mem_result     = r_result;
    assign mem_zero       = r_zero;
    assign mem_store_data = r_store_data;
    assign mem_wreg       = r_wreg;
    assign mem_ctrl       = r_ctrl;
    assign div_busy       = w_busy;

`ifdef EXMEM_FWD_EN
    assign fwd_valid = r_valid & r_ctrl[CTRL_REGWRITE] & (r_wreg != 5'd0);
    assign fwd_wreg  = r_wreg;
    assign fwd_data  = r_result;
`endif

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning divider latency in cycles from DIVU issue until HI/LO is valid; legal range 2..64.
REQ-002 SHALL have parameter DIVU_CODE, default 4'b0100, meaning the ALU Signal value that denotes DIVU.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_valid  in  1  EX stage holds a live instruction.
REQ-006 SHALL have port ex_alu_sig  in  4  ALU Signal of the EX instruction.
REQ-007 SHALL have port ex_hilo_rd  in  1  EX instruction is MFHI or MFLO.
REQ-008 SHALL have ports ex_result in 32 (ALU Output), ex_zero in 1 (ALU zero), ex_store_data in 32 (rt value), ex_wreg in 5 (destination register).
REQ-009 SHALL have port ex_ctrl  in  4  {RegWrite, MemRead, MemWrite, MemToReg}.
REQ-010 SHALL have port mem_stall  in  1  MEM stage cannot accept a new entry.
REQ-011 SHALL have port flush  in  1  kill the EX-stage instruction.
REQ-012 SHALL have port ex_stall  out  1  hold EX and all upstream stages.
REQ-013 SHALL have ports mem_valid out 1, mem_result out 32, mem_zero out 1, mem_store_data out 32, mem_wreg out 5, mem_ctrl out 4 (registered EX/MEM contents).
REQ-014 SHALL have port div_busy  out  1  divide in progress.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY with a down-counter of width clog2(DIV_CYCLES).
REQ-016 DIVU issue SHALL occur when state is IDLE, ex_valid=1, ex_alu_sig=DIVU_CODE, flush=0 and mem_stall=0.
REQ-017 On DIVU issue, the FSM SHALL go to BUSY with the counter loaded to DIV_CYCLES-1, and DIVU SHALL enter MEM with mem_valid=1 and mem_ctrl=0.
REQ-018 In BUSY the counter SHALL decrement every cycle, independent of mem_stall and flush; at count 0 the FSM SHALL return to IDLE on the next edge.
REQ-019 div_busy SHALL be 1 exactly while state is BUSY.
REQ-020 ex_stall SHALL be combinational and equal to mem_stall OR (BUSY AND ex_valid AND (ex_hilo_rd OR ex_alu_sig=DIVU_CODE)) OR (IDLE AND mem_stall); flush SHALL force ex_stall=0.
REQ-021 If mem_stall=1, all mem_* registers SHALL hold their values.
REQ-022 Else if flush=1, or ex_valid=0, or a BUSY-induced stall is in effect, the stage SHALL register a bubble: mem_valid=0, mem_ctrl=0, data fields retained.
REQ-023 Otherwise all ex_* fields SHALL be captured into mem_* with mem_valid=1, so latency is one cycle.
REQ-024 Non-HI/LO, non-DIVU instructions SHALL pass during BUSY without stalling.
REQ-025 A DIVU killed by flush SHALL NOT start the counter, and flush during BUSY SHALL NOT abort the divide.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, counter 0, mem_valid 0, mem_ctrl 0, mem_result/mem_store_data 0, mem_wreg 0 and mem_zero 0, which gives ex_stall=mem_stall and div_busy=0.
REQ-027 Reset asserted during BUSY SHALL abandon the divide with no residual stall.

Configuration
REQ-028 With EXMEM_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_wreg (5) and fwd_data (32).
REQ-029 fwd_valid SHALL equal mem_valid AND RegWrite AND mem_wreg!=0, with fwd_wreg=mem_wreg and fwd_data=mem_result.
REQ-030 Without EXMEM_FWD_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package mips_pkg SHALL hold the ctrl bit indices, the DIVU/ALU Signal codes, the FSM state encoding and the ctrl field width.
REQ-032 Sub-module div_busy_ctr SHALL own the FSM and counter, with inputs issue and clk/reset and output busy; ex_mem_stage SHALL own the pipeline registers and stall logic.

Verification
REQ-033 The bench SHALL apply reset low mid-stream -> all mem_* outputs 0 and div_busy=0 within the same cycle, without a clock edge.
REQ-034 The bench SHALL issue DIVU then MFHI on the next cycle with DIV_CYCLES=32 -> ex_stall=1 for 32 cycles, bubbles in MEM, MFHI enters MEM on the 33rd edge after issue.
REQ-035 The bench SHALL issue DIVU then three ADDs -> ADDs flow with 1-cycle latency, ex_stall=0, div_busy=1.
REQ-036 The bench SHALL hold mem_stall=1 for 5 cycles with ex_result=0x1234 -> mem_* unchanged and ex_stall=1 throughout; on release, mem_result=0x1234 next edge.
REQ-037 The bench SHALL apply flush together with DIVU -> mem_valid=0 and div_busy stays 0.
REQ-038 With EXMEM_FWD_EN, the bench SHALL pass ADD to wreg=0 with RegWrite=1 -> fwd_valid=0; wreg=5 -> fwd_valid=1, fwd_data=mem_result.
